// File: rtl/id_ex_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_skid
// Description : Two-entry elastic pipeline stage (head + skid register) with
//               valid/ready handshake, flush-driven bubble insertion, debug
//               step freeze and a saturating count of flushed entries.
//               Generic payload: a control bus (zeroed whenever its entry is
//               not valid) and a data bus (held unless explicitly cleared).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_step_en      debug step enable; 0 freezes all transfers
//   i_flush        synchronous flush; discards every held entry
//   i_valid        upstream entry valid
//   o_ready        stage can accept an entry this cycle
//   i_ctrl         upstream control payload  [CTRL_W]
//   i_data         upstream data payload     [DATA_W]
//   o_valid        head entry valid (registered)
//   i_ready        downstream accepts the head entry
//   o_ctrl         head control payload      [CTRL_W]
//   o_data         head data payload         [DATA_W]
//   o_occupancy    number of held entries (0, 1 or 2)
//   o_bubble_cnt   saturating count of valid entries discarded by flush
// ============================================================================
module id_ex_stage_skid #(
    parameter int unsigned CTRL_W              = 24,
    parameter int unsigned DATA_W              = 122,
    parameter int unsigned CNT_W               = 16,
    parameter bit          CLEAR_DATA_ON_FLUSH = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_step_en,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_occupancy,
    output logic [CNT_W-1:0]  o_bubble_cnt
);

    // State encoding equals the number of held entries so that the
    // occupancy output is the state register itself.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic                r_head_valid;
    logic [CTRL_W-1:0]   r_head_ctrl;
    logic [DATA_W-1:0]   r_head_data;
    logic                r_skid_valid;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CNT_W-1:0]    r_bubble_cnt;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    state_t              w_state_nxt;
    logic                w_head_valid_nxt;
    logic [CTRL_W-1:0]   w_head_ctrl_nxt;
    logic [DATA_W-1:0]   w_head_data_nxt;
    logic                w_skid_valid_nxt;
    logic [CTRL_W-1:0]   w_skid_ctrl_nxt;
    logic [DATA_W-1:0]   w_skid_data_nxt;
    logic [CNT_W-1:0]    w_bubble_cnt_nxt;

    logic                w_accept;
    logic                w_drain;
    logic [1:0]          w_discard;
    logic [CNT_W:0]      w_cnt_sum;

    // Ready depends only on registered state, reset and the step enable so
    // that no combinational path exists from i_valid or i_ready to o_ready.
    assign o_ready  = ~i_rst & i_step_en & ~r_skid_valid;

    assign w_accept = i_valid & o_ready;
    assign w_drain  = r_head_valid & i_ready & i_step_en;

    // ------------------------------------------------------------------
    // Bubble counter: a head leaving downstream in the flush cycle is
    // consumed, not discarded, so only the remaining entries are counted.
    // The sum is one bit wider so overflow is visible and clamps.
    // ------------------------------------------------------------------
    always_comb begin
        w_discard = 2'd0;
        if (i_flush) begin
            w_discard = {1'b0, r_head_valid & ~w_drain} + {1'b0, r_skid_valid};
        end
    end

    assign w_cnt_sum = {1'b0, r_bubble_cnt} + (CNT_W+1)'(w_discard);

    always_comb begin
        w_bubble_cnt_nxt = w_cnt_sum[CNT_W-1:0];
        if (w_cnt_sum[CNT_W]) begin
            w_bubble_cnt_nxt = c_cnt_max;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and payload steering
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_head_valid_nxt = r_head_valid;
        w_head_ctrl_nxt  = r_head_ctrl;
        w_head_data_nxt  = r_head_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_ctrl_nxt  = r_skid_ctrl;
        w_skid_data_nxt  = r_skid_data;

        if (i_flush) begin
            // Flush wins over accept, drain and freeze; an input offered in
            // the same cycle is dropped.
            w_state_nxt      = S_EMPTY;
            w_head_valid_nxt = 1'b0;
            w_head_ctrl_nxt  = '0;
            w_skid_valid_nxt = 1'b0;
            w_skid_ctrl_nxt  = '0;
            if (CLEAR_DATA_ON_FLUSH) begin
                w_head_data_nxt = '0;
                w_skid_data_nxt = '0;
            end
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt      = S_ONE;
                        w_head_valid_nxt = 1'b1;
                        w_head_ctrl_nxt  = i_ctrl;
                        w_head_data_nxt  = i_data;
                    end
                end

                S_ONE: begin
                    if (w_accept && w_drain) begin
                        // Pass-through: head replaced in the same cycle.
                        w_head_ctrl_nxt  = i_ctrl;
                        w_head_data_nxt  = i_data;
                    end else if (w_accept) begin
                        // Downstream stalled: park the new entry in skid.
                        w_state_nxt      = S_TWO;
                        w_skid_valid_nxt = 1'b1;
                        w_skid_ctrl_nxt  = i_ctrl;
                        w_skid_data_nxt  = i_data;
                    end else if (w_drain) begin
                        w_state_nxt      = S_EMPTY;
                        w_head_valid_nxt = 1'b0;
                        w_head_ctrl_nxt  = '0;
                    end
                end

                S_TWO: begin
                    // o_ready is low here, so only the drain path exists.
                    if (w_drain) begin
                        w_state_nxt      = S_ONE;
                        w_head_ctrl_nxt  = r_skid_ctrl;
                        w_head_data_nxt  = r_skid_data;
                        w_skid_valid_nxt = 1'b0;
                        w_skid_ctrl_nxt  = '0;
                    end
                end

                default: begin
                    // Unused encoding: recover to a clean empty stage.
                    w_state_nxt      = S_EMPTY;
                    w_head_valid_nxt = 1'b0;
                    w_head_ctrl_nxt  = '0;
                    w_skid_valid_nxt = 1'b0;
                    w_skid_ctrl_nxt  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_EMPTY;
            r_head_valid <= 1'b0;
            r_head_ctrl  <= '0;
            r_head_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_head_valid <= w_head_valid_nxt;
            r_head_ctrl  <= w_head_ctrl_nxt;
            r_head_data  <= w_head_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_ctrl  <= w_skid_ctrl_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_bubble_cnt <= w_bubble_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_valid      = r_head_valid;
    assign o_ctrl       = r_head_ctrl;
    assign o_data       = r_head_data;
    assign o_occupancy  = r_state;
    assign o_bubble_cnt = r_bubble_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage_skid
// Description : Self-checking bench for id_ex_stage_skid. A queue-based model
//               of the stage is compared with the DUT every cycle; directed
//               sequences pin the model with hand-computed literals, followed
//               by randomized traffic bursts separated by resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_skid;

    localparam int CTRL_W  = 24;
    localparam int DATA_W  = 122;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              step_en = 1'b1;
    logic              flush = 1'b0;
    logic              vin = 1'b0;
    logic              rdy = 1'b0;
    logic [CTRL_W-1:0] cin = '0;
    logic [DATA_W-1:0] din = '0;

    logic              o_ready;
    logic              o_valid;
    logic [CTRL_W-1:0] o_ctrl;
    logic [DATA_W-1:0] o_data;
    logic [1:0]        o_occupancy;
    logic [CNT_W-1:0]  o_bubble_cnt;

    id_ex_stage_skid #(
        .CTRL_W              (CTRL_W),
        .DATA_W              (DATA_W),
        .CNT_W               (CNT_W),
        .CLEAR_DATA_ON_FLUSH (1'b0)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_step_en    (step_en),
        .i_flush      (flush),
        .i_valid      (vin),
        .o_ready      (o_ready),
        .i_ctrl       (cin),
        .i_data       (din),
        .o_valid      (o_valid),
        .i_ready      (rdy),
        .o_ctrl       (o_ctrl),
        .o_data       (o_data),
        .o_occupancy  (o_occupancy),
        .o_bubble_cnt (o_bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a FIFO of at most two entries, a flushed-entry count
    // and the last data value that reached the head.
    // ------------------------------------------------------------------
    ent_t              mq[$];
    int                m_cnt = 0;
    logic [DATA_W-1:0] m_last = '0;
    bit                m_ready, m_acc, m_drn;
    int                m_disc;
    ent_t              m_tmp;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_cnt  = 0;
            m_last = '0;
        end else begin
            m_ready = step_en && (mq.size() < 2);
            m_acc   = vin && m_ready;
            m_drn   = (mq.size() > 0) && rdy && step_en;
            if (flush) begin
                m_disc = mq.size() - (m_drn ? 1 : 0);
                m_cnt  = (m_cnt + m_disc > CNT_MAX) ? CNT_MAX : m_cnt + m_disc;
                mq.delete();
            end else begin
                if (m_drn) void'(mq.pop_front());
                if (m_acc) begin
                    m_tmp.c = cin;
                    m_tmp.d = din;
                    mq.push_back(m_tmp);
                end
            end
            if (mq.size() > 0) m_last = mq[0].d;
        end
        #1;
        if (chk_en) begin
            check("m_valid", o_valid, (mq.size() > 0) ? 1 : 0);
            check("m_ctrl",  o_ctrl,  (mq.size() > 0) ? mq[0].c : '0);
            check("m_data",  o_data,  m_last);
            check("m_occ",   o_occupancy, mq.size());
            check("m_cnt",   o_bubble_cnt, m_cnt);
            check("m_ready", o_ready, (!rst && step_en && mq.size() < 2) ? 1 : 0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic logic [CTRL_W-1:0] ec(input int i);
        return 24'h000100 + 24'(i);
    endfunction

    function automatic logic [DATA_W-1:0] ed(input int i);
        return {58'h1, 32'(i), 32'h40};
    endfunction

    // Drive one cycle's inputs at the falling edge, return just after the
    // following rising edge so outputs reflect the transfer.
    task automatic step(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input bit r, input bit f, input bit se);
        @(negedge clk);
        vin = v; cin = c; din = d; rdy = r; flush = f; step_en = se;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; vin = 1'b0; flush = 1'b0; rdy = 1'b0; step_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [127:0] rnd;

    initial begin
        chk_en = 1'b1;
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_ctrl",  o_ctrl, 0);
        check("rst_data",  o_data, 0);
        check("rst_occ",   o_occupancy, 0);
        check("rst_cnt",   o_bubble_cnt, 0);
        check("rst_ready", o_ready, 0);
        rst = 1'b0;

        // Fill and drain with 1-cycle latency
        step(1, 24'h00A5A5, 122'h40, 1, 0, 1);
        check("fill_valid", o_valid, 1);
        check("fill_ctrl",  o_ctrl, 24'h00A5A5);
        check("fill_data",  o_data, 122'h40);
        step(0, '0, '0, 1, 0, 1);
        check("drain_valid", o_valid, 0);
        check("drain_ctrl",  o_ctrl, 0);
        check("drain_occ",   o_occupancy, 0);
        check("drain_data_hold", o_data, 122'h40);

        // Back-pressure into skid
        step(1, ec(1), ed(1), 0, 0, 1);
        check("skid_occ1", o_occupancy, 1);
        step(1, ec(2), ed(2), 0, 0, 1);
        check("skid_occ2",   o_occupancy, 2);
        check("skid_ready0", o_ready, 0);
        check("skid_head",   o_ctrl, ec(1));
        step(1, ec(3), ed(3), 0, 0, 1);
        check("skid_hold",   o_ctrl, ec(1));
        step(1, ec(3), ed(3), 1, 0, 1);
        check("skid_e2",     o_ctrl, ec(2));
        check("skid_e2_occ", o_occupancy, 1);
        step(1, ec(3), ed(3), 1, 0, 1);
        check("skid_e3",     o_ctrl, ec(3));
        step(1, ec(4), ed(4), 1, 0, 1);
        check("skid_e4",     o_ctrl, ec(4));
        check("skid_e4_data", o_data, ed(4));
        step(0, '0, '0, 1, 0, 1);
        check("skid_empty",  o_valid, 0);

        // Flush while full, with an input offered
        step(1, ec(1), ed(1), 0, 0, 1);
        step(1, ec(2), ed(2), 0, 0, 1);
        step(1, ec(3), ed(3), 0, 1, 1);
        check("fl_valid", o_valid, 0);
        check("fl_ctrl",  o_ctrl, 0);
        check("fl_occ",   o_occupancy, 0);
        check("fl_cnt",   o_bubble_cnt, 2);
        check("fl_data",  o_data, ed(1));
        step(0, '0, '0, 0, 0, 1);
        check("fl_no_e3", o_valid, 0);

        // Flush with drain: head consumed, not counted
        step(1, ec(5), ed(5), 0, 0, 1);
        step(0, '0, '0, 1, 1, 1);
        check("fld_cnt",   o_bubble_cnt, 2);
        check("fld_valid", o_valid, 0);
        step(1, ec(6), ed(6), 0, 0, 1);
        step(0, '0, '0, 0, 1, 1);
        check("sat_cnt3",  o_bubble_cnt, 3);
        step(1, ec(7), ed(7), 0, 0, 1);
        step(0, '0, '0, 0, 1, 1);
        check("sat_stick", o_bubble_cnt, 3);

        // Step freeze
        step(1, ec(7), ed(7), 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, ec(8), ed(8), 1, 0, 0);
            check("frz_ready", o_ready, 0);
            check("frz_ctrl",  o_ctrl, ec(7));
            check("frz_data",  o_data, ed(7));
            check("frz_occ",   o_occupancy, 1);
        end
        step(1, ec(8), ed(8), 1, 0, 1);
        check("frz_next", o_ctrl, ec(8));
        step(0, '0, '0, 1, 0, 1);

        // Asynchronous reset between edges while full
        step(1, ec(9), ed(9), 0, 0, 1);
        step(1, ec(10), ed(10), 0, 0, 1);
        check("ar_pre_occ", o_occupancy, 2);
        @(negedge clk);
        vin = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("ar_valid", o_valid, 0);
        check("ar_occ",   o_occupancy, 0);
        check("ar_ctrl",  o_ctrl, 0);
        check("ar_data",  o_data, 0);
        check("ar_cnt",   o_bubble_cnt, 0);
        check("ar_ready", o_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Randomized bursts, reset between them so the counter restarts
        for (int b = 0; b < 4; b++) begin
            for (int n = 0; n < 500; n++) begin
                @(negedge clk);
                rnd     = {$urandom(), $urandom(), $urandom(), $urandom()};
                vin     = ($urandom_range(99, 0) < 70);
                rdy     = ($urandom_range(99, 0) < 55);
                flush   = ($urandom_range(99, 0) < 4);
                step_en = ($urandom_range(99, 0) < 85);
                cin     = rnd[CTRL_W-1:0];
                din     = rnd[DATA_W-1:0] ^ {DATA_W{b[0]}};
            end
            do_reset();
        end

        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
